// File: rtl/sar_pkg.sv
// Shared types and elaboration helpers for the two-step SAR controller.
// Used by sar2_ctrl and its phase timer.
package sar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_COMP,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } sar_state_e;

    function automatic int step_cyc(input int cmp_wait);
        return 2 + cmp_wait;
    endfunction

    function automatic int tmr_width(input int sample_cyc, input int cmp_wait);
        int m;
        m = (sample_cyc > cmp_wait) ? sample_cyc : cmp_wait;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(
        input int nc,
        input int nf,
        input int sample_cyc,
        input int cmp_wait
    );
        return (nc >= 1) && (nf >= 1) && (sample_cyc >= 1) && (cmp_wait >= 0);
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter timing the SAMPLE and SETTLE phases.
// done is high in the last cycle of a loaded phase.
module sar_phase_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/sar2_ctrl.sv
// Two-step coarse/fine SAR conversion controller with a
// valid/ready result port and sticky overrun flag.
module sar2_ctrl
    import sar_pkg::*;
#(
    parameter int NC         = 4,
    parameter int NF         = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int CMP_WAIT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnvst,
    input  logic             cont,
    input  logic             cmp_out,
    output logic             s_clk,
    output logic             cmp_clk,
    output logic [NC+NF-1:0] dac_code,
    output logic [NF-1:0]    fine_a,
    output logic [NF-1:0]    fine_b,
    output logic             fine_up,
    output logic             fine_switch,
    output logic             busy,
    output logic [NC+NF-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    localparam int W  = NC + NF;
    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam int TW = tmr_width(SAMPLE_CYC, CMP_WAIT);
    localparam int STEP = step_cyc(CMP_WAIT);
    localparam bit NO_SETTLE = (CMP_WAIT == 0);

    localparam logic [W-1:0]  ONE_W = W'(1);
    localparam logic [NF-1:0] ONE_F = NF'(1);
    localparam logic [KW-1:0] K_NF  = KW'(NF);
    localparam logic [KW-1:0] K_TOP = KW'(W - 1);

    if (!params_ok(NC, NF, SAMPLE_CYC, CMP_WAIT) || STEP < 2) begin : g_bad
        $error("sar2_ctrl: NC, NF and SAMPLE_CYC must be >= 1");
    end

    sar_state_e state;
    sar_state_e state_nxt;

    logic [KW-1:0] k;
    logic          bnd;
    logic          start;
    logic          last_dec;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic          s_clk_nxt;
    logic          cmp_clk_nxt;
    logic          busy_nxt;

    logic          is_bnd;
    logic          is_coarse;
    logic          is_fine;
    logic [W-1:0]  bit_k;
    logic [NF-1:0] fbit;
    logic          d;
    logic          hs;

    sar_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    assign last_dec = !bnd && (k == '0);
    assign start    = (state == ST_IDLE) && (state_nxt == ST_SAMPLE);
    assign tmr_load = start
                   || ((state == ST_COMP) && (state_nxt == ST_SETTLE));
    assign tmr_val  = (state == ST_IDLE) ? TW'(SAMPLE_CYC) : TW'(CMP_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (cnvst || cont) state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (tmr_done) state_nxt = ST_COMP;
            ST_COMP:   state_nxt = NO_SETTLE ? ST_DECIDE : ST_SETTLE;
            ST_SETTLE: if (tmr_done) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = last_dec ? ST_DONE : ST_COMP;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state.
    always_comb begin
        s_clk_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_SAMPLE);
        cmp_clk_nxt = (state_nxt == ST_COMP);
        busy_nxt    = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_clk   <= 1'b1;
            cmp_clk <= 1'b0;
            busy    <= 1'b0;
        end else begin
            s_clk   <= s_clk_nxt;
            cmp_clk <= cmp_clk_nxt;
            busy    <= busy_nxt;
        end
    end

    assign is_bnd    = bnd;
    assign is_coarse = !bnd && (k >= K_NF);
    assign is_fine   = !bnd && (k < K_NF);
    assign bit_k     = ONE_W << k;
    assign fbit      = ONE_F << k;
    assign d         = cmp_out ^ fine_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code    <= '0;
            fine_a      <= '0;
            fine_b      <= '0;
            fine_up     <= 1'b0;
            fine_switch <= 1'b0;
            k           <= '0;
            bnd         <= 1'b0;
        end else if (start) begin
            dac_code    <= ONE_W << (W - 1);
            fine_a      <= '0;
            fine_b      <= '0;
            fine_up     <= 1'b0;
            fine_switch <= 1'b0;
            k           <= K_TOP;
            bnd         <= 1'b0;
        end else if (state == ST_DECIDE) begin
            unique case (1'b1)
                is_bnd: begin
                    fine_up     <= cmp_out;
                    fine_switch <= 1'b1;
                    dac_code    <= dac_code | bit_k;
                    bnd         <= 1'b0;
                end
                is_coarse: begin
                    // The last coarse bit hands over to the bound step.
                    dac_code <= (cmp_out ? dac_code : dac_code & ~bit_k)
                              | ((k != K_NF) ? (bit_k >> 1) : '0);
                    bnd      <= (k == K_NF);
                    k        <= k - KW'(1);
                end
                is_fine: begin
                    dac_code <= (d ? dac_code : dac_code & ~bit_k)
                              | ((k != '0) ? (bit_k >> 1) : '0);
                    fine_a   <= fine_a | (d ? fbit : '0);
                    fine_b   <= fine_b | (d ? '0 : fbit);
                    if (k != '0) begin
                        k <= k - KW'(1);
                    end
                end
                default: begin
                    bnd <= 1'b0;
                end
            endcase
        end else if (state == ST_DONE) begin
            fine_switch <= 1'b0;
        end
    end

    assign hs = dout_valid && dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (state == ST_DONE) begin
            dout       <= dac_code;
            dout_valid <= 1'b1;
            if (dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end else if (hs) begin
                overrun <= 1'b0;
            end
        end else if (hs) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar2_ctrl.sv
// Bench for sar2_ctrl: vector table, random decisions against a
// bit-level result model, and hand-written multi-cycle sequences.
module tb_sar2_ctrl;

    localparam int NC   = 4;
    localparam int NF   = 4;
    localparam int W    = NC + NF;
    localparam int WB   = W + 1;
    localparam int SC   = 2;
    localparam int LAT1 = 1 + SC + (W + 1) * (2 + 1) + 1;
    localparam int LAT0 = 1 + SC + (W + 1) * (2 + 0) + 1;
    localparam int TMO  = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnvst = 1'b0;
    logic          cont = 1'b0;
    logic          cmp_out = 1'b0;
    logic          dout_ready = 1'b0;
    logic          s_clk, cmp_clk, fine_up, fine_switch, busy;
    logic          dout_valid, overrun;
    logic [W-1:0]  dac_code, dout;
    logic [NF-1:0] fine_a, fine_b;

    logic          cnvst0 = 1'b0;
    logic          cmp_out0 = 1'b1;
    logic          dout_ready0 = 1'b1;
    logic          cont0 = 1'b0;
    logic          s_clk0, cmp_clk0, fine_up0, fine_switch0, busy0;
    logic          dout_valid0, overrun0;
    logic [W-1:0]  dac_code0, dout0;
    logic [NF-1:0] fine_a0, fine_b0;

    sar2_ctrl #(
        .NC(NC), .NF(NF), .SAMPLE_CYC(SC), .CMP_WAIT(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cnvst(cnvst), .cont(cont),
        .cmp_out(cmp_out), .s_clk(s_clk), .cmp_clk(cmp_clk),
        .dac_code(dac_code), .fine_a(fine_a), .fine_b(fine_b),
        .fine_up(fine_up), .fine_switch(fine_switch), .busy(busy),
        .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .overrun(overrun)
    );

    sar2_ctrl #(
        .NC(NC), .NF(NF), .SAMPLE_CYC(SC), .CMP_WAIT(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cnvst(cnvst0), .cont(cont0),
        .cmp_out(cmp_out0), .s_clk(s_clk0), .cmp_clk(cmp_clk0),
        .dac_code(dac_code0), .fine_a(fine_a0), .fine_b(fine_b0),
        .fine_up(fine_up0), .fine_switch(fine_switch0), .busy(busy0),
        .dout(dout0), .dout_valid(dout_valid0),
        .dout_ready(dout_ready0), .overrun(overrun0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0]    bits;
        logic [W-1:0]  dout;
        logic [NF-1:0] fa;
        logic [NF-1:0] fb;
        logic          up;
    } vec_t;

    vec_t tbl[4];
    int   checks = 0;
    int   errors = 0;
    logic q[$];
    int   pulses = 0;

    // Comparator stand-in: presents the next decision while cmp_clk is high.
    always @(negedge clk) begin
        if (cmp_clk) begin
            pulses = pulses + 1;
            cmp_out = (q.size() > 0) ? q.pop_front() : 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Coarse bits are taken as-is; fine bits are the comparator
    // results re-referenced to the bound chosen in the middle step.
    function automatic vec_t model(input logic [W:0] b);
        vec_t          r;
        logic [NC-1:0] c;
        logic [NF-1:0] f;
        c = b[W:NF+1];
        f = b[NF-1:0] ^ {NF{b[NF]}};
        r.bits = b;
        r.dout = {c, f};
        r.fa   = f;
        r.fb   = ~f;
        r.up   = b[NF];
        return r;
    endfunction

    task automatic run_conv(input logic [W:0] b, input int glitch_at,
                            output int lat, output int np);
        int p0;
        for (int i = W; i >= 0; i--) q.push_back(b[i]);
        @(negedge clk);
        p0 = pulses;
        cnvst = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cnvst = (lat == glitch_at);
            if (lat == SC + 2) begin
                chk("busy_mid", 32'(busy), 32'd1);
                chk("s_clk_mid", 32'(s_clk), 32'd0);
            end
        end while (!dout_valid && lat < TMO);
        cnvst = 1'b0;
        np = pulses - p0;
    endtask

    task automatic check_conv(input string tag, input vec_t e,
                              input int lat, input int np);
        chk({tag, "_dout"}, 32'(dout), 32'(e.dout));
        chk({tag, "_fine_a"}, 32'(fine_a), 32'(e.fa));
        chk({tag, "_fine_b"}, 32'(fine_b), 32'(e.fb));
        chk({tag, "_fine_up"}, 32'(fine_up), 32'(e.up));
        chk({tag, "_latency"}, 32'(lat), 32'(LAT1));
        chk({tag, "_cmp_pulses"}, 32'(np), 32'(W + 1));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        chk({tag, "_valid_clr"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        int   np;
        int   n;
        vec_t e;
        logic [W:0] b;

        tbl[0] = '{9'b1011_1_0100, 8'hBB, 4'b1011, 4'b0100, 1'b1};
        tbl[1] = '{9'b1111_0_1111, 8'hFF, 4'hF, 4'h0, 1'b0};
        tbl[2] = '{9'b0000_0_0000, 8'h00, 4'h0, 4'hF, 1'b0};
        tbl[3] = '{9'b0101_1_1111, 8'h50, 4'h0, 4'hF, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_s_clk", 32'(s_clk), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmp_clk", 32'(cmp_clk), 32'd0);
        chk("rst_dac_code", 32'(dac_code), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_fine_switch", 32'(fine_switch), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_conv(tbl[i].bits, 0, lat, np);
            check_conv($sformatf("tbl%0d", i), tbl[i], lat, np);
        end

        for (int i = 0; i < 16; i++) begin
            b = WB'($urandom);
            e = model(b);
            run_conv(b, 0, lat, np);
            check_conv($sformatf("rnd%0d", i), e, lat, np);
        end

        run_conv(tbl[0].bits, 10, lat, np);
        check_conv("glitch", tbl[0], lat, np);

        // Back-to-back conversions with nothing reading the port.
        for (int i = W; i >= 0; i--) q.push_back(tbl[0].bits[i]);
        for (int i = W; i >= 0; i--) q.push_back(tbl[1].bits[i]);
        @(negedge clk);
        cont = 1'b1;
        n = 0;
        while (!dout_valid && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("cont_first_dout", 32'(dout), 32'hBB);
        chk("cont_gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("cont_restart_busy", 32'(busy), 32'd1);
        cont = 1'b0;
        n = 0;
        while (!overrun && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_dout", 32'(dout), 32'hFF);
        chk("ovr_valid", 32'(dout_valid), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovr_idle_busy", 32'(busy), 32'd0);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        chk("ovr_hs_valid", 32'(dout_valid), 32'd0);
        chk("ovr_hs_flag", 32'(overrun), 32'd0);

        // Reset in the fine phase, then a clean conversion.
        for (int i = W; i >= 0; i--) q.push_back(tbl[0].bits[i]);
        @(negedge clk);
        cnvst = 1'b1;
        @(negedge clk);
        cnvst = 1'b0;
        repeat (21) @(negedge clk);
        chk("mid_fine_switch", 32'(fine_switch), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_clk", 32'(s_clk), 32'd1);
        chk("mid_rst_dac", 32'(dac_code), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fsw", 32'(fine_switch), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(tbl[1].bits, 0, lat, np);
        check_conv("after_rst", tbl[1], lat, np);

        // No-settle instance, comparator held high.
        e = model(9'b1111_1_1111);
        @(negedge clk);
        cnvst0 = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            cnvst0 = 1'b0;
        end while (!dout_valid0 && n < TMO);
        chk("nowait_latency", 32'(n), 32'(LAT0));
        chk("nowait_dout", 32'(dout0), 32'(e.dout));
        chk("nowait_fine_a", 32'(fine_a0), 32'(e.fa));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
